// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver (16x oversampled) feeding a valid/ready holding register.
// Define RX_PARITY_EN to receive 8E1 frames with even-parity checking.
`timescale 1ns/1ps
module uart_rx_deframer #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       UART_RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       parity_error,
  output logic       rx_busy
);
  localparam int DIV  = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int HALF = OVERSAMPLE / 2;
  localparam int TW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW   = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
`ifdef RX_PARITY_EN
    , PARITY = 3'd5
`endif
  } state_t;

  state_t          state_r;
  logic            sync1_r;
  logic            rxd_s;
  logic [TW-1:0]   tick_cnt_r;
  logic            tick_s;
  logic [SW-1:0]   sample_cnt_r;
  logic            sample_end_s;
  logic [2:0]      bit_cnt_r;
  logic [7:0]      shift_r;
  logic            deliver_r;

`ifdef RX_PARITY_EN
  logic            par_bad_r;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  assign parity_error = 1'b0;
`endif

  assign tick_s       = (tick_cnt_r == TW'(DIV - 1));
  assign sample_end_s = tick_s && (sample_cnt_r == SW'(OVERSAMPLE - 1));

  // Two-flop synchronizer, preset to the idle (mark) level.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_r <= 1'b1;
      rxd_s   <= 1'b1;
    end else begin
      sync1_r <= UART_RXD;
      rxd_s   <= sync1_r;
    end
  end

  // Sample-tick divider; parked at zero in IDLE so every frame starts phase-aligned.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_cnt_r <= {TW{1'b0}};
    end else if (state_r == IDLE || tick_s) begin
      tick_cnt_r <= {TW{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  // Frame FSM: start validation, bit sampling, stop check and error pulses.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r       <= IDLE;
      sample_cnt_r  <= {SW{1'b0}};
      bit_cnt_r     <= 3'd0;
      shift_r       <= 8'h00;
      deliver_r     <= 1'b0;
      framing_error <= 1'b0;
      rx_busy       <= 1'b0;
`ifdef RX_PARITY_EN
      par_bad_r     <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      deliver_r     <= 1'b0;
      framing_error <= 1'b0;
`ifdef RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          sample_cnt_r <= {SW{1'b0}};
          bit_cnt_r    <= 3'd0;
          if (!rxd_s) begin
            state_r <= START;
            rx_busy <= 1'b1;
          end
        end
        START: if (tick_s) begin
          if (sample_cnt_r == SW'(HALF - 1)) begin
            sample_cnt_r <= {SW{1'b0}};
            if (rxd_s) begin
              state_r <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state_r <= DATA;
            end
          end else begin
            sample_cnt_r <= sample_cnt_r + SW'(1);
          end
        end
        DATA: if (sample_end_s) begin
          sample_cnt_r <= {SW{1'b0}};
          shift_r      <= {rxd_s, shift_r[7:1]};
          bit_cnt_r    <= bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
`ifdef RX_PARITY_EN
            state_r <= PARITY;
`else
            state_r <= STOP;
`endif
          end
        end else if (tick_s) begin
          sample_cnt_r <= sample_cnt_r + SW'(1);
        end
`ifdef RX_PARITY_EN
        PARITY: if (sample_end_s) begin
          sample_cnt_r <= {SW{1'b0}};
          par_bad_r    <= (rxd_s != even_parity(shift_r));
          state_r      <= STOP;
        end else if (tick_s) begin
          sample_cnt_r <= sample_cnt_r + SW'(1);
        end
`endif
        STOP: if (sample_end_s) begin
          sample_cnt_r <= {SW{1'b0}};
          if (rxd_s) begin
            state_r <= IDLE;
            rx_busy <= 1'b0;
`ifdef RX_PARITY_EN
            if (par_bad_r) begin
              parity_error <= 1'b1;
            end else begin
              deliver_r <= 1'b1;
            end
`else
            deliver_r <= 1'b1;
`endif
          end else begin
            framing_error <= 1'b1;
            state_r       <= BREAK;
          end
        end else if (tick_s) begin
          sample_cnt_r <= sample_cnt_r + SW'(1);
        end
        BREAK: if (rxd_s) begin
          state_r <= IDLE;
          rx_busy <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: load when empty or drained this cycle, otherwise drop and flag overrun.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (deliver_r) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_r;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: directed frames plus randomized frames
// checked against a byte/event-level model of the receiver.
`timescale 1ns/1ps
module tb_uart_rx_deframer;
  localparam int CLK_HZ = 50000000;
  localparam int BAUD   = 115200;
  localparam int OS     = 16;
  localparam int DIV    = (CLK_HZ + BAUD * OS / 2) / (BAUD * OS);
  localparam int BIT    = DIV * OS;
`ifdef RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int EXP_LAT = 2 + (OS / 2 + (9 + PAR_EN) * OS) * DIV + 1;

  logic       CLOCK_50;
  logic       RESET_N;
  logic       UART_RXD;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_error;
  logic       overrun;
  logic       parity_error;
  logic       rx_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -100000;
  int n_rise = 0, n_hi = 0, n_fe = 0, n_ov = 0, n_pe = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int r0, hi0, fe0, ov0, pe0, efe, epe, lat, hit;
  bit seen;
  logic [7:0] d;
  logic bad, pf;

  uart_rx_deframer #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .CLOCK_50     (CLOCK_50),
    .RESET_N      (RESET_N),
    .UART_RXD     (UART_RXD),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .framing_error(framing_error),
    .overrun      (overrun),
    .parity_error (parity_error),
    .rx_busy      (rx_busy)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  initial forever begin
    @(posedge CLOCK_50);
    cyc++;
  end

  // Event monitor: counts output pulses and records bytes taken by the consumer.
  initial forever begin
    @(negedge CLOCK_50);
    #1;
    if (rx_valid && !prev_valid) begin
      n_rise++;
      rise_cyc = cyc;
    end
    if (rx_valid) n_hi++;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (framing_error) n_fe++;
    if (overrun) n_ov++;
    if (parity_error) n_pe++;
    prev_valid = rx_valid;
  end

  initial begin
    #(20 * 150000);
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic snap();
    r0 = n_rise; hi0 = n_hi; fe0 = n_fe; ov0 = n_ov; pe0 = n_pe;
  endtask

  // Drives one frame: start, 8 data bits LSB first, optional parity, stop.
  task automatic send_frame(input logic [7:0] db, input logic stop_b, input logic pflip);
    @(negedge CLOCK_50);
    UART_RXD  = 1'b0;
    start_cyc = cyc;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      UART_RXD = db[i];
      idle(BIT);
    end
    if (PAR_EN != 0) begin
      UART_RXD = (^db) ^ pflip;
      idle(BIT);
    end
    UART_RXD = stop_b;
    idle(BIT);
  endtask

  initial begin
    RESET_N  = 1'b1;
    UART_RXD = 1'b1;
    rx_ready = 1'b0;
    #5 RESET_N = 1'b0;
    idle(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_err", {framing_error, overrun, parity_error}, 0);
    RESET_N = 1'b1;
    idle(20);

    // Single 0x55 frame: latency, data, one-cycle valid, no errors
    rx_ready = 1'b1;
    got_q.delete();
    snap();
    send_frame(8'h55, 1'b1, 1'b0);
    idle(BIT);
    lat = rise_cyc - start_cyc;
    check("lat55", (lat >= EXP_LAT - 2 && lat <= EXP_LAT + 2) ? EXP_LAT : lat, EXP_LAT);
    check("cnt55", got_q.size(), 1);
    if (got_q.size() > 0) check("data55", got_q[0], 8'h55);
    check("hi55", n_hi - hi0, 1);
    check("err55", (n_fe - fe0) + (n_ov - ov0) + (n_pe - pe0), 0);

    // Randomized frames against the reference model
    got_q.delete();
    exp_q.delete();
    efe = 0;
    epe = 0;
    snap();
    for (int k = 0; k < 5; k++) begin
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      pf  = (PAR_EN != 0) && ($urandom_range(0, 2) == 0);
      send_frame(d, !bad, pf);
      if (bad) begin
        efe++;
        idle($urandom_range(1, 600));
        UART_RXD = 1'b1;
      end else if (pf) begin
        epe++;
      end else begin
        exp_q.push_back(d);
      end
      idle(20 + $urandom_range(0, 200));
    end
    idle(BIT);
    check("rand_cnt", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rand_byte%0d", i), got_q[i], exp_q[i]);
    check("rand_fe", n_fe - fe0, efe);
    check("rand_pe", n_pe - pe0, epe);
    check("rand_ov", n_ov - ov0, 0);

    // 100-clock glitch: false start, no output
    snap();
    UART_RXD = 1'b0;
    idle(50);
    check("glitch_busy", rx_busy, 1);
    idle(50);
    UART_RXD = 1'b1;
    idle(300);
    check("glitch_idle", rx_busy, 0);
    check("glitch_out", (n_rise - r0) + (n_fe - fe0) + (n_pe - pe0), 0);

    // Framing error and break, then recovery with 0x12
    snap();
    send_frame(8'hA3, 1'b0, 1'b0);
    idle(1000);
    check("brk_busy", rx_busy, 1);
    idle(1000);
    check("brk_fe", n_fe - fe0, 1);
    check("brk_valid", n_rise - r0, 0);
    UART_RXD = 1'b1;
    idle(10);
    check("brk_idle", rx_busy, 0);
    got_q.delete();
    send_frame(8'h12, 1'b1, 1'b0);
    idle(BIT);
    check("rec_cnt", got_q.size(), 1);
    if (got_q.size() > 0) check("rec_data", got_q[0], 8'h12);

    // Overrun: 0xA5 held, 0x3C dropped
    rx_ready = 1'b0;
    got_q.delete();
    snap();
    send_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(BIT);
    check("ovr_data", rx_data, 8'hA5);
    check("ovr_valid", rx_valid, 1);
    check("ovr_pulse", n_ov - ov0, 1);
    rx_ready = 1'b1;
    @(negedge CLOCK_50);
    rx_ready = 1'b0;
    @(negedge CLOCK_50);
    #2;
    check("ovr_drain", rx_valid, 0);
    check("ovr_taken", (got_q.size() == 1) ? got_q[0] : 8'hXX, 8'hA5);

    // Consume on the exact delivery cycle: replaced in place, no overrun
    got_q.delete();
    snap();
    send_frame(8'h01, 1'b1, 1'b0);
    idle(BIT);
    check("sim_first", rx_data, 8'h01);
    hit  = 0;
    seen = 1'b0;
    fork
      send_frame(8'h02, 1'b1, 1'b0);
      begin
        for (int i = 0; i < 6000; i++) begin
          @(negedge CLOCK_50);
          if (rx_busy) begin
            seen = 1'b1;
          end else if (seen) begin
            rx_ready = 1'b1;
            @(negedge CLOCK_50);
            rx_ready = 1'b0;
            hit = 1;
            break;
          end
        end
      end
    join
    idle(20);
    check("sim_hit", hit, 1);
    check("sim_valid", rx_valid, 1);
    check("sim_data", rx_data, 8'h02);
    check("sim_ov", n_ov - ov0, 0);
    check("sim_taken", (got_q.size() == 1) ? got_q[0] : 8'hXX, 8'h01);

    // Reset in the middle of a 0xFF frame, then a clean 0x81
    @(negedge CLOCK_50);
    UART_RXD = 1'b0;
    idle(BIT);
    UART_RXD = 1'b1;
    idle(BIT);
    #3 RESET_N = 1'b0;
    #1;
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_busy", rx_busy, 0);
    idle(5);
    RESET_N = 1'b1;
    idle(100);
    got_q.delete();
    snap();
    rx_ready = 1'b1;
    send_frame(8'h81, 1'b1, (PAR_EN != 0));
    idle(BIT);
`ifdef RX_PARITY_EN
    check("post_pe", n_pe - pe0, 1);
    check("post_valid", n_rise - r0, 0);
`else
    check("post_cnt", got_q.size(), 1);
    if (got_q.size() > 0) check("post_data", got_q[0], 8'h81);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
